// File: rtl/rv32i_types_pkg.sv
// Shared core types: CDB entry layout, default tag/index widths and FU slot numbering.
package rv32i_types;

    localparam int CDB_PREG_W = 6;
    localparam int CDB_ROB_W  = 5;
    localparam int CDB_DATA_W = 32;

    typedef struct packed {
        logic                  regwrite;
        logic [CDB_PREG_W-1:0] preg;
        logic [CDB_ROB_W-1:0]  rob;
        logic [CDB_DATA_W-1:0] data;
    } cdb_entry_t;

    localparam int CDB_ENTRY_W = $bits(cdb_entry_t);

    localparam int ALU_IDX = 0;
    localparam int MUL_IDX = 1;
    localparam int DIV_IDX = 2;
    localparam int MEM_IDX = 3;
    localparam int BRU_IDX = 4;

    // Modular increment that stays correct when n is not a power of two.
    function automatic int fu_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_fu_buf.sv
// Per-FU completion buffer: small circular FIFO holding finished results until they win the CDB.
module cdb_fu_buf #(
    parameter int DEPTH = 2,
    parameter int W     = 44,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [2**PTR_W];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_en;
    logic             pop_en;

    assign push_en = push && !flush && (count < CNT_W'(DEPTH));
    assign pop_en  = pop && !flush && (count != '0);
    assign head    = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_en)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is data only; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Multi-channel common data bus: per-FU completion buffers, round-robin grant of up to
// NUM_CDB heads per cycle, registered broadcast toward rob/resv/regfile/dispatch/fetch.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_FU    = 5,
    parameter int NUM_CDB   = 2,
    parameter int BUF_DEPTH = 2,
    parameter int PREG_W    = CDB_PREG_W,
    parameter int ROB_W     = CDB_ROB_W,
    parameter int DATA_W    = CDB_DATA_W,
    parameter int SRC_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_FU-1:0]         fu_valid,
    output logic [NUM_FU-1:0]         fu_ready,
    input  logic [NUM_FU-1:0]         fu_regwrite,
    input  logic [NUM_FU*PREG_W-1:0]  fu_preg,
    input  logic [NUM_FU*ROB_W-1:0]   fu_rob,
    input  logic [NUM_FU*DATA_W-1:0]  fu_data,
    output logic [NUM_CDB-1:0]        cdb_valid,
    output logic [NUM_CDB-1:0]        cdb_regwrite,
    output logic [NUM_CDB*PREG_W-1:0] cdb_preg,
    output logic [NUM_CDB*ROB_W-1:0]  cdb_rob,
    output logic [NUM_CDB*DATA_W-1:0] cdb_data,
    output logic [NUM_CDB*SRC_W-1:0]  cdb_src
);

    localparam int ENT_W = 1 + PREG_W + ROB_W + DATA_W;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [ENT_W-1:0]  fu_ent [NUM_FU];
    logic [ENT_W-1:0]  head   [NUM_FU];
    logic [CNT_W-1:0]  count  [NUM_FU];
    logic [NUM_FU-1:0] nonempty;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;

    genvar i;
    generate
        for (i = 0; i < NUM_FU; i++) begin : g_fu
            assign fu_ent[i]   = {fu_regwrite[i],
                                  fu_preg[i*PREG_W +: PREG_W],
                                  fu_rob[i*ROB_W +: ROB_W],
                                  fu_data[i*DATA_W +: DATA_W]};
            assign fu_ready[i] = (count[i] < CNT_W'(BUF_DEPTH));
            assign nonempty[i] = (count[i] != '0);
            assign push[i]     = fu_valid[i] & fu_ready[i] & ~flush;

            cdb_fu_buf #(
                .DEPTH (BUF_DEPTH),
                .W     (ENT_W),
                .CNT_W (CNT_W)
            ) u_buf (
                .clk   (clk),
                .rst   (rst),
                .flush (flush),
                .push  (push[i]),
                .pop   (pop[i]),
                .din   (fu_ent[i]),
                .head  (head[i]),
                .count (count[i])
            );
        end
    endgenerate

    logic [NUM_CDB-1:0] gnt_vld;
    logic [ENT_W-1:0]   gnt_ent [NUM_CDB];
    logic [SRC_W-1:0]   gnt_src [NUM_CDB];
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   last_gnt;
    logic               any_gnt;
    int                 scan;
    int                 n_gnt;

    // Scan from rr_ptr with wrap; the j-th non-empty buffer found drives channel j.
    always_comb begin
        pop      = '0;
        gnt_vld  = '0;
        any_gnt  = 1'b0;
        last_gnt = rr_ptr;
        n_gnt    = 0;
        scan     = 0;
        for (int k = 0; k < NUM_CDB; k++) begin
            gnt_ent[k] = '0;
            gnt_src[k] = '0;
        end
        for (int s = 0; s < NUM_FU; s++) begin
            scan = int'(rr_ptr) + s;
            if (scan >= NUM_FU) scan = scan - NUM_FU;
            if (nonempty[scan] && (n_gnt < NUM_CDB)) begin
                pop[scan]      = 1'b1;
                gnt_vld[n_gnt] = 1'b1;
                gnt_ent[n_gnt] = head[scan];
                gnt_src[n_gnt] = SRC_W'(scan);
                last_gnt       = SRC_W'(scan);
                any_gnt        = 1'b1;
                n_gnt          = n_gnt + 1;
            end
        end
    end

    logic [NUM_CDB-1:0]        nxt_regwrite;
    logic [NUM_CDB*PREG_W-1:0] nxt_preg;
    logic [NUM_CDB*ROB_W-1:0]  nxt_rob;
    logic [NUM_CDB*DATA_W-1:0] nxt_data;
    logic [NUM_CDB*SRC_W-1:0]  nxt_src;

    genvar c;
    generate
        for (c = 0; c < NUM_CDB; c++) begin : g_ch
            assign nxt_regwrite[c]                = gnt_ent[c][ENT_W-1];
            assign nxt_preg[c*PREG_W +: PREG_W]   = gnt_ent[c][ENT_W-2 -: PREG_W];
            assign nxt_rob[c*ROB_W +: ROB_W]      = gnt_ent[c][DATA_W +: ROB_W];
            assign nxt_data[c*DATA_W +: DATA_W]   = gnt_ent[c][DATA_W-1:0];
            assign nxt_src[c*SRC_W +: SRC_W]      = gnt_src[c];
        end
    endgenerate

    // Broadcast register stage; flush drops whatever was granted this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid    <= '0;
            cdb_regwrite <= '0;
            cdb_preg     <= '0;
            cdb_rob      <= '0;
            cdb_data     <= '0;
            cdb_src      <= '0;
            rr_ptr       <= '0;
        end else if (flush) begin
            cdb_valid    <= '0;
            cdb_regwrite <= '0;
            cdb_preg     <= '0;
            cdb_rob      <= '0;
            cdb_data     <= '0;
            cdb_src      <= '0;
        end else begin
            cdb_valid    <= gnt_vld;
            cdb_regwrite <= nxt_regwrite;
            cdb_preg     <= nxt_preg;
            cdb_rob      <= nxt_rob;
            cdb_data     <= nxt_data;
            cdb_src      <= nxt_src;
            if (any_gnt) rr_ptr <= SRC_W'(fu_wrap_inc(int'(last_gnt), NUM_FU));
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench: instance a (2 channels) for reset/latency/contention/flush,
// instance b (1 channel) for backpressure and fairness.
module tb_cdb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [4:0]   a_valid = '0, a_rw = '0, a_ready;
    logic [29:0]  a_preg = '0;
    logic [24:0]  a_rob = '0;
    logic [159:0] a_data = '0;
    logic [1:0]   a_cv, a_crw;
    logic [11:0]  a_cpreg;
    logic [9:0]   a_crob;
    logic [63:0]  a_cdata;
    logic [5:0]   a_csrc;

    logic [4:0]   b_valid = '0, b_rw = '0, b_ready;
    logic [29:0]  b_preg = '0;
    logic [24:0]  b_rob = '0;
    logic [159:0] b_data = '0;
    logic [0:0]   b_cv, b_crw;
    logic [5:0]   b_cpreg;
    logic [4:0]   b_crob;
    logic [31:0]  b_cdata;
    logic [2:0]   b_csrc;

    cdb_arbiter #(.NUM_FU(5), .NUM_CDB(2), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush_a),
        .fu_valid(a_valid), .fu_ready(a_ready), .fu_regwrite(a_rw),
        .fu_preg(a_preg), .fu_rob(a_rob), .fu_data(a_data),
        .cdb_valid(a_cv), .cdb_regwrite(a_crw), .cdb_preg(a_cpreg),
        .cdb_rob(a_crob), .cdb_data(a_cdata), .cdb_src(a_csrc)
    );

    cdb_arbiter #(.NUM_FU(5), .NUM_CDB(1), .BUF_DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b),
        .fu_valid(b_valid), .fu_ready(b_ready), .fu_regwrite(b_rw),
        .fu_preg(b_preg), .fu_rob(b_rob), .fu_data(b_data),
        .cdb_valid(b_cv), .cdb_regwrite(b_crw), .cdb_preg(b_cpreg),
        .cdb_rob(b_crob), .cdb_data(b_cdata), .cdb_src(b_csrc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          ch;
        int          src;
        logic        rw;
        logic [5:0]  preg;
        logic [4:0]  rob;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t e;

    task automatic a_offer(input int fu, input logic rw, input logic [5:0] pg,
                           input logic [4:0] rb, input logic [31:0] d);
        a_valid[fu] = 1'b1;
        a_rw[fu] = rw;
        a_preg[fu*6 +: 6] = pg;
        a_rob[fu*5 +: 5] = rb;
        a_data[fu*32 +: 32] = d;
    endtask

    task automatic a_expect(input int ch, input int src, input logic rw, input logic [5:0] pg,
                            input logic [4:0] rb, input logic [31:0] d, input int off);
        exp_t x;
        x.ch = ch; x.src = src; x.rw = rw; x.preg = pg; x.rob = rb; x.data = d;
        x.cyc = cyc + off;
        qa.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor for instance a: every channel of every cycle is checked.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                total++;
                if (a_cv[k]) begin
                    if (qa.size() == 0) begin
                        bad++;
                        $display("FAIL a_unexpected ch%0d: got src=%0d data=%h, required no broadcast",
                                 k, a_csrc[k*3 +: 3], a_cdata[k*32 +: 32]);
                    end else begin
                        e = qa.pop_front();
                        if (e.ch != k || e.src != int'(a_csrc[k*3 +: 3]) || e.rw !== a_crw[k] ||
                            e.preg !== a_cpreg[k*6 +: 6] || e.rob !== a_crob[k*5 +: 5] ||
                            e.data !== a_cdata[k*32 +: 32] || e.cyc != cyc) begin
                            bad++;
                            $display("FAIL a_bcast ch%0d cyc%0d: got src=%0d rw=%0d preg=%0d rob=%0d data=%h, required ch%0d cyc%0d src=%0d rw=%0d preg=%0d rob=%0d data=%h",
                                     k, cyc, a_csrc[k*3 +: 3], a_crw[k], a_cpreg[k*6 +: 6], a_crob[k*5 +: 5],
                                     a_cdata[k*32 +: 32], e.ch, e.cyc, e.src, e.rw, e.preg, e.rob, e.data);
                        end
                    end
                end else if (a_crw[k] !== 1'b0 || a_cpreg[k*6 +: 6] !== '0 || a_crob[k*5 +: 5] !== '0 ||
                             a_cdata[k*32 +: 32] !== '0 || a_csrc[k*3 +: 3] !== '0) begin
                    bad++;
                    $display("FAIL a_idle_fields ch%0d: got rw=%0d preg=%0d rob=%0d data=%h src=%0d, required all 0",
                             k, a_crw[k], a_cpreg[k*6 +: 6], a_crob[k*5 +: 5], a_cdata[k*32 +: 32], a_csrc[k*3 +: 3]);
                end
            end
        end
    end

    logic [31:0] qb [5][$];
    int          b_seq [5];
    int          b_gnts [5];
    int          b_mode = 0;
    int          b_exp_src = 0;
    int          bs;
    logic [31:0] bd;
    logic [4:0]  b_dropped = '0;

    task automatic b_drive(input logic [4:0] mask);
        for (int i = 0; i < 5; i++) begin
            if (mask[i] && b_ready[i]) begin
                b_valid[i] = 1'b1;
                b_rw[i] = 1'b1;
                b_preg[i*6 +: 6] = 6'(i);
                b_rob[i*5 +: 5] = 5'(b_seq[i]);
                b_data[i*32 +: 32] = {8'(i), 24'(b_seq[i])};
                qb[i].push_back({8'(i), 24'(b_seq[i])});
                b_seq[i]++;
            end else begin
                b_valid[i] = 1'b0;
                if (mask[i]) b_dropped[i] = 1'b1;
            end
        end
    endtask

    // Monitor for instance b: per-FU order plus grant-order model.
    always @(negedge clk) begin
        if (!rst && b_cv[0]) begin
            bs = int'(b_csrc);
            total++;
            if (bs >= 5) begin
                bad++;
                $display("FAIL b_src_range: got %0d, required < 5", bs);
            end else if (qb[bs].size() == 0) begin
                bad++;
                $display("FAIL b_unexpected: got src=%0d data=%h, required no broadcast", bs, b_cdata);
            end else begin
                bd = qb[bs].pop_front();
                if (b_cdata !== bd || b_crw !== 1'b1 || b_cpreg !== 6'(bs)) begin
                    bad++;
                    $display("FAIL b_order fu%0d: got data=%h rw=%0d preg=%0d, required data=%h rw=1 preg=%0d",
                             bs, b_cdata, b_crw, b_cpreg, bd, bs);
                end
            end
            if (b_mode == 1) begin
                total++;
                if (bs != b_exp_src) begin
                    bad++;
                    $display("FAIL b_rotate: got src=%0d, required %0d", bs, b_exp_src);
                end
                b_exp_src = (b_exp_src + 1) % 5;
            end else if (b_mode == 2) begin
                total++;
                if (bs != b_exp_src) begin
                    bad++;
                    $display("FAIL b_alternate: got src=%0d, required %0d", bs, b_exp_src);
                end
                b_exp_src = (b_exp_src == 4) ? 0 : 4;
            end
            if (bs < 5) b_gnts[bs]++;
        end
    end

    initial begin
        for (int i = 0; i < 5; i++) begin
            b_seq[i] = 0;
            b_gnts[i] = 0;
        end
        repeat (2) @(negedge clk);
        check("ready_in_reset", 32'(a_ready), 32'h1f);
        check("cdb_valid_in_reset", 32'(a_cv), 32'h0);
        rst = 1'b0;

        // Reset with 3 entries buffered and both channels live
        @(negedge clk);
        for (int i = 0; i < 5; i++) a_offer(i, 1'b1, 6'(10 + i), 5'(i), 32'h1000 + i);
        a_expect(0, 0, 1'b1, 6'd10, 5'd0, 32'h1000, 2);
        a_expect(1, 1, 1'b1, 6'd11, 5'd1, 32'h1001, 2);
        @(negedge clk);
        a_valid = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_valid", 32'(a_cv), 32'h0);
        check("async_reset_ready", 32'(a_ready), 32'h1f);
        @(negedge clk);
        check("reset_held_ready", 32'(a_ready), 32'h1f);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single result, 2-edge latency
        a_offer(2, 1'b1, 6'd7, 5'd3, 32'hDEADBEEF);
        a_expect(0, 2, 1'b1, 6'd7, 5'd3, 32'hDEADBEEF, 2);
        @(negedge clk);
        a_valid = '0;
        repeat (4) @(negedge clk);
        check("single_drained", 32'(qa.size()), 32'h0);

        // Contention from rr_ptr = 0
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 5; i++) a_offer(i, (i != 4), 6'(20 + i), 5'(8 + i), 32'hA0 + i);
        a_expect(0, 0, 1'b1, 6'd20, 5'd8,  32'hA0, 2);
        a_expect(1, 1, 1'b1, 6'd21, 5'd9,  32'hA1, 2);
        a_expect(0, 2, 1'b1, 6'd22, 5'd10, 32'hA2, 3);
        a_expect(1, 3, 1'b1, 6'd23, 5'd11, 32'hA3, 3);
        a_expect(0, 4, 1'b0, 6'd24, 5'd12, 32'hA4, 4);
        @(negedge clk);
        a_valid = '0;
        repeat (5) @(negedge clk);
        check("contention_drained", 32'(qa.size()), 32'h0);

        // rr_ptr back at 0: FU0 must lead FU3, FU4 follows
        a_offer(3, 1'b1, 6'd30, 5'd13, 32'hB3);
        a_offer(4, 1'b1, 6'd31, 5'd14, 32'hB4);
        a_offer(0, 1'b1, 6'd32, 5'd15, 32'hB0);
        a_expect(0, 0, 1'b1, 6'd32, 5'd15, 32'hB0, 2);
        a_expect(1, 3, 1'b1, 6'd30, 5'd13, 32'hB3, 2);
        a_expect(0, 4, 1'b1, 6'd31, 5'd14, 32'hB4, 3);
        @(negedge clk);
        a_valid = '0;
        repeat (4) @(negedge clk);
        check("wrap_drained", 32'(qa.size()), 32'h0);

        // Flush with 4 entries buffered and FU1 offering
        a_valid = '0;
        for (int i = 0; i < 5; i++) a_offer(i, 1'b1, 6'(40 + i), 5'(16 + i), 32'hF0 + i);
        a_expect(0, 0, 1'b1, 6'd40, 5'd16, 32'hF0, 2);
        a_expect(1, 1, 1'b1, 6'd41, 5'd17, 32'hF1, 2);
        @(negedge clk);
        a_valid = '0;
        a_offer(0, 1'b1, 6'd50, 5'd20, 32'hBAD0);
        @(negedge clk);
        a_valid = '0;
        a_offer(1, 1'b1, 6'd51, 5'd21, 32'hBAD1);
        flush_a = 1'b1;
        @(negedge clk);
        flush_a = 1'b0;
        a_valid = '0;
        check("flush_valid", 32'(a_cv), 32'h0);
        check("flush_ready", 32'(a_ready), 32'h1f);
        repeat (6) @(negedge clk);
        check("flush_drained", 32'(qa.size()), 32'h0);

        // Backpressure, one channel
        do_reset();
        b_mode = 1;
        b_exp_src = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            b_drive(5'h1f);
        end
        b_mode = 0;
        @(negedge clk);
        b_valid = '0;
        repeat (20) @(negedge clk);
        check("bp_ready_dropped", 32'(b_dropped), 32'h1f);
        for (int i = 0; i < 5; i++) check("bp_fu_drained", 32'(qb[i].size()), 32'h0);
        check("bp_fu0_count", 32'(b_gnts[0]), 32'(b_seq[0]));

        // Fairness: rr_ptr primed to 1 so FU4 leads
        do_reset();
        @(negedge clk);
        b_drive(5'h01);
        @(negedge clk);
        b_valid = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) b_gnts[i] = 0;
        b_exp_src = 4;
        b_mode = 2;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            b_drive(5'h11);
        end
        @(negedge clk);
        b_valid = '0;
        repeat (6) @(negedge clk);
        b_mode = 0;
        check("fair_fu0_share", 32'(b_gnts[0] >= 45), 32'h1);
        check("fair_fu4_share", 32'(b_gnts[4] >= 45), 32'h1);
        check("fair_others_idle", 32'(b_gnts[1] + b_gnts[2] + b_gnts[3]), 32'h0);
        check("fair_fu0_drained", 32'(qb[0].size()), 32'h0);
        check("fair_fu4_drained", 32'(qb[4].size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Parametrised common-data-bus arbiter for the out-of-order core. It replaces the single shared CDB with NUM_CDB broadcast channels fed by NUM_FU functional units (alu, mul, div, mem, bru, ...).
- Each FU gets a small completion buffer, so an FU can retire a result even when it loses arbitration.
- Round-robin arbitration grants up to NUM_CDB buffered results per cycle.
- Broadcasts are registered toward rob, resv, regfile, dispatch and fetch.
- A mispredict flush empties all pending results.

Parameters:
NUM_FU, 5, number of functional-unit producers
NUM_CDB, 2, number of broadcast channels (1 <= NUM_CDB <= NUM_FU)
BUF_DEPTH, 2, entries per FU completion buffer (power of two, >= 1)
PREG_W, 6, physical register tag width
ROB_W, 5, ROB index width
DATA_W, 32, result width
SRC_W, $clog2(NUM_FU), FU index width (minimum 1)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
flush  in  1  mispredict flush, synchronous
fu_valid  in  NUM_FU  result offered by FU i
fu_ready  out  NUM_FU  FU i buffer can accept this cycle
fu_regwrite  in  NUM_FU  result writes a physical register
fu_preg  in  NUM_FU*PREG_W  destination tag, FU i at slice i
fu_rob  in  NUM_FU*ROB_W  ROB index
fu_data  in  NUM_FU*DATA_W  result value
cdb_valid  out  NUM_CDB  channel k broadcast valid
cdb_regwrite  out  NUM_CDB  channel k writes a register
cdb_preg  out  NUM_CDB*PREG_W  channel k tag
cdb_rob  out  NUM_CDB*ROB_W  channel k ROB index
cdb_data  out  NUM_CDB*DATA_W  channel k value
cdb_src  out  NUM_CDB*SRC_W  FU index that produced channel k

Behaviour:
- Reset (async, active-high):
  - All buffers empty, rr_ptr = 0.
  - All cdb_* outputs = 0.
  - fu_ready = all 1s, including while rst is held.
- fu_ready[i] = (count[i] < BUF_DEPTH). It is a function of registered state only, with no combinational path from fu_valid.
- Push: fu_valid[i] & fu_ready[i] & ~flush writes {regwrite, preg, rob, data} to the tail of buffer i.
- fu_valid while not ready is a protocol error. The FU must hold its result, and the arbiter ignores it.
- Per-FU FIFO order is preserved.
- Arbitration, each cycle:
  - Candidates are the non-empty buffers.
  - Scan indices rr_ptr, rr_ptr+1, ... modulo NUM_FU.
  - The first NUM_CDB candidates are granted, at most one per FU.
  - The j-th grant in scan order drives channel j.
- Pop: granted heads are popped the same cycle.
  - A push and a pop on the same buffer in one cycle are legal; count is unchanged.
  - A push into an empty buffer cannot be granted that cycle; the minimum latency is 2 edges.
- Broadcast: on the next edge cdb_*[j] <= granted head j and cdb_valid[j] <= 1.
  - Unused channels get cdb_valid = 0 and all other channel fields = 0.
  - Latency, measured with no contention: a push at edge t appears on the CDB after edge t+1.
- rr_ptr update:
  - After any grant, rr_ptr <= (index of last grant + 1) mod NUM_FU.
  - With no grant, rr_ptr is unchanged.
  - Wrap-around from NUM_FU-1 to 0 must be correct for non-power-of-two NUM_FU.
- Flush (highest priority):
  - On the edge where flush = 1, all counts go to 0, no push is accepted, and all cdb_valid <= 0.
  - rr_ptr is unchanged.
  - Results granted in the flush cycle are discarded.
  - The cycle after flush, fu_ready = all 1s.
- A cdb_valid=1 whose cdb_regwrite=0 (store, branch) still marks the ROB entry done. Consumers must not wake tags on it.
- No output depends combinationally on any input.

Decomposition:
- Shared package rv32i_types carries cdb_entry_t {regwrite, preg, rob, data}. Keep the PREG_W/ROB_W defaults in sync with that package.
- The package also defines the FU index constants ALU_IDX, MUL_IDX, DIV_IDX, MEM_IDX, BRU_IDX.
- One sub-module, cdb_fu_buf: a BUF_DEPTH circular FIFO with push, pop, flush, count, head. It is instantiated NUM_FU times via generate.
- The arbiter scan is a combinational loop in the top module.

Test Plan:
1. Reset: assert rst while buffers hold 3 entries and cdb_valid = 2'b11. Required: cdb_valid = 0 immediately without a clock edge, and fu_ready = 5'b11111. After release, no stale entry is ever broadcast.
2. Single result: FU2 pushes {regwrite=1, preg=7, rob=3, data=0xDEADBEEF} at edge t. Required: after t+1, cdb_valid = 2'b01, ch0 carries those values with cdb_src = 2, and ch1 fields = 0.
3. Contention, NUM_CDB=2, rr_ptr=0: all 5 FUs push once at the same edge. Required grants on the following edges:
   - ch0/ch1 = FU0/FU1, then FU2/FU3, then FU4/none.
   - rr_ptr ends at 0.
4. Backpressure, NUM_CDB=1, BUF_DEPTH=2: all FUs push continuously whenever ready, with incrementing data per FU. Required:
   - Each fu_ready drops once the buffer is full.
   - No result is lost or duplicated, and per-FU data arrives strictly in order.
   - Grants rotate 0,1,2,3,4,0,...
5. Flush: with 4 entries buffered, pulse flush while FU1 offers a result. Required: all cdb_valid = 0 on the next cycle, fu_ready = all 1s, and neither the flushed entries nor FU1's offered result ever appear.
6. Fairness and wrap, NUM_CDB=1: FU0 and FU4 are continuously valid. Required: grants alternate FU4, FU0, FU4, ... with no starvation over 100 cycles.
